// File: rtl/uart_pkg.sv
// Shared UART definitions: frame layout, transmitter states and the even-parity
// rule used by both the transmitter and the oversampling receiver.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } tx_state_e;

  // Even parity: the parity bit makes the total count of ones in data+parity even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO in front of the serialiser; the head byte is visible
// combinationally on dout so the FSM can load it on the pop edge.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr];
  assign count  = r_count;

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes sent as start, 8 data bits LSB first,
// even parity and stop, with back-to-back frames when more bytes are queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 27000000,
  parameter int BAUD_RATE  = 1000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          Tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int              BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
  localparam int              CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0]   BIT_LAST   = CW'(BIT_CYCLES - 1);

  tx_state_e               r_state;
  logic [CW-1:0]           r_bit_cnt;
  logic [2:0]              r_bit_idx;
  logic [DATA_BITS-1:0]    r_shift;
  logic                    r_parity;
  logic                    r_tx;

  logic [7:0]              w_head;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_bit_end;
  logic                    w_pop;
  logic                    w_line;

  assign w_bit_end = (r_bit_cnt == BIT_LAST);
  assign w_pop     = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
  assign tx_ready  = !w_full;
  assign busy      = (r_state != S_IDLE) || (fifo_count != '0);
  assign Tx        = r_tx;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_valid),
    .pop   (w_pop),
    .din   (tx_data),
    .dout  (w_head),
    .count (fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Line level implied by the current state; registered into r_tx one cycle later.
  always_comb begin
    w_line = 1'b1;
    case (r_state)
      S_IDLE:   w_line = 1'b1;
      S_START:  w_line = 1'b0;
      S_DATA:   w_line = r_shift[0];
      S_PARITY: w_line = r_parity;
      S_STOP:   w_line = 1'b1;
      default:  w_line = 1'b1;
    endcase
  end

  // Frame sequencer, bit timer, shift register and parity latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_tx      <= w_line;
      r_bit_cnt <= (r_state == S_IDLE || w_bit_end) ? '0 : r_bit_cnt + CW'(1);
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_shift   <= w_head;
            r_parity  <= even_parity(w_head);
            r_bit_idx <= 3'd0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= S_PARITY;
          end
        end
        S_PARITY: begin
          if (w_bit_end) r_state <= S_STOP;
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (!w_empty) begin
              r_shift   <= w_head;
              r_parity  <= even_parity(w_head);
              r_bit_idx <= 3'd0;
              r_state   <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a mid-bit sampling receiver model pops expected bytes
// from a scoreboard filled at push time, plus timing and corner-case sequences.
module tb_uart_tx;

  localparam int BIT   = 27;
  localparam int FRAME = 297;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       Tx;
  logic       busy;
  logic [2:0] fifo_count;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  int         starts[$];
  int         frame_cnt = 0;
  int         cyc = 0;
  bit         rx_active = 1'b0;
  logic [7:0] last_data;
  logic       last_par;

  uart_tx #(.CLOCK_FREQ(27000000), .BAUD_RATE(1000000), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .Tx         (Tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Receiver model: detects the start edge, samples each bit mid-way.
  initial begin
    int         cnt;
    logic [10:0] bits;
    logic [7:0] exp_b;
    cnt  = 0;
    bits = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst !== 1'b1) begin
        rx_active = 1'b0;
      end else if (!rx_active) begin
        if (Tx === 1'b0) begin
          rx_active = 1'b1;
          cnt       = 0;
          bits      = '0;
          starts.push_back(cyc);
        end
      end else begin
        cnt++;
        if (cnt % BIT == BIT / 2) begin
          bits[cnt / BIT] = Tx;
          if (cnt / BIT == 10) begin
            rx_active = 1'b0;
            frame_cnt++;
            last_data = bits[8:1];
            last_par  = bits[9];
            check("rx_start_bit", 32'(bits[0]), 32'd0);
            check("rx_stop_bit", 32'(bits[10]), 32'd1);
            check("rx_parity", 32'(bits[9]), 32'(^bits[8:1]));
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rx_unexpected_frame: got 0x%0h expected none", bits[8:1]);
            end else begin
              exp_b = sb.pop_front();
              check("rx_data", 32'(bits[8:1]), 32'(exp_b));
            end
          end
        end
      end
    end
  end

  // Called at a negedge; drives one byte for exactly one rising edge.
  task automatic push_byte(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    if (tx_ready) sb.push_back(d);
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while ((busy || rx_active) && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy || rx_active) begin
      errors++;
      $display("FAIL idle_timeout: got busy=%0d after %0d cycles expected idle", busy, n);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vec_t        vecs[7];
    logic [10:0] a5_frame;
    logic        exp_tx;
    int          busy_cnt;
    int          f0;

    vecs[0] = '{data: 8'hA5, par: 1'b0};
    vecs[1] = '{data: 8'h01, par: 1'b1};
    vecs[2] = '{data: 8'hFF, par: 1'b0};
    vecs[3] = '{data: 8'h00, par: 1'b0};
    vecs[4] = '{data: 8'h3C, par: 1'b0};
    vecs[5] = '{data: 8'hC3, par: 1'b0};
    vecs[6] = '{data: 8'h07, par: 1'b1};
    a5_frame = {1'b1, 1'b0, 8'hA5, 1'b0};

    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rst      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(Tx), 32'd1);
    check("reset_ready", 32'(tx_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5 from idle: two-cycle latency to start bit, exact bit widths, busy length.
    push_byte(8'hA5);
    busy_cnt = 0;
    for (int k = 0; k <= 300; k++) begin
      if (busy) busy_cnt++;
      exp_tx = (k < 2 || k > 298) ? 1'b1 : a5_frame[(k - 2) / BIT];
      check("a5_tx_cycle", 32'(Tx), 32'(exp_tx));
      @(negedge clk);
    end
    check("a5_busy_cycles", 32'(busy_cnt), 32'd298);
    wait_idle(50);

    // Table of bytes: data and parity bit as seen by the receiver model.
    for (int i = 0; i < 7; i++) begin
      f0 = frame_cnt;
      push_byte(vecs[i].data);
      wait_idle(400);
      check("vec_frames", 32'(frame_cnt - f0), 32'd1);
      check("vec_data", 32'(last_data), 32'(vecs[i].data));
      check("vec_parity", 32'(last_par), 32'(vecs[i].par));
    end

    // Overflow: six consecutive pushes while idle, depth 4.
    starts.delete();
    f0 = frame_cnt;
    for (int i = 0; i < 6; i++) begin
      tx_data  = 8'(8'h10 + i);
      tx_valid = 1'b1;
      check("ovf_ready", 32'(tx_ready), (i < 5) ? 32'd1 : 32'd0);
      if (tx_ready) sb.push_back(tx_data);
      @(posedge clk);
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("ovf_count", 32'(fifo_count), 32'd4);
    wait_idle(5 * FRAME + 100);
    check("ovf_frames", 32'(frame_cnt - f0), 32'd5);
    check("ovf_starts", 32'(starts.size()), 32'd5);
    for (int i = 1; i < starts.size(); i++) begin
      check("ovf_b2b_gap", 32'(starts[i] - starts[i-1]), 32'(FRAME));
    end

    // Push on the pop edge with one byte held: count stays 1, order kept.
    f0 = frame_cnt;
    push_byte(8'hAA);
    check("pp_count_before", 32'(fifo_count), 32'd1);
    push_byte(8'hBB);
    check("pp_count_after", 32'(fifo_count), 32'd1);
    wait_idle(2 * FRAME + 100);
    check("pp_frames", 32'(frame_cnt - f0), 32'd2);
    check("pp_last", 32'(last_data), 32'hBB);

    // Reset during data bit 3 of 0x55 with two bytes queued.
    push_byte(8'h55);
    push_byte(8'h66);
    push_byte(8'h77);
    repeat (115) @(negedge clk);
    check("rst_pre_tx_bit3", 32'(Tx), 32'd0);
    check("rst_pre_count", 32'(fifo_count), 32'd2);
    rst = 1'b0;
    #1;
    check("rst_tx_high", 32'(Tx), 32'd1);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    sb.delete();
    f0 = frame_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (Tx !== 1'b1 || busy !== 1'b0) begin
        check("rst_quiet_line", {30'd0, busy, Tx}, 32'd1);
        break;
      end
    end
    check("rst_no_frame", 32'(frame_cnt - f0), 32'd0);
    push_byte(8'h81);
    wait_idle(400);
    check("rst_new_frame", 32'(frame_cnt - f0), 32'd1);
    check("rst_new_data", 32'(last_data), 32'h81);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
